// File: rtl/rvv_insn_issue.sv
// rvv_insn_issue
// In-order issue stage in front of rvv_proc_main. Incoming vector instructions
// are buffered in a small FIFO. The head instruction is decoded and held back
// while any register it reads or writes still has a write in flight. Each
// cycle that nothing is issued, the stage emits a NOP (all zeros).
//
// Ports
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   insn_in      : instruction from fetch, qualified by insn_valid
//   insn_ready   : FIFO has room; independent of a same-cycle pop
//   flush        : synchronous discard of every buffered instruction
//   insn_out     : registered instruction to rvv_proc_main (0 = NOP)
//   stall        : registered; head was present but held by a hazard
//   fifo_count   : current FIFO occupancy
module rvv_insn_issue #(
  parameter int INSN_WIDTH = 32,
  parameter int NUM_VEC    = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int WB_LAT     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [INSN_WIDTH-1:0]         insn_in,
  input  logic                          insn_valid,
  output logic                          insn_ready,
  input  logic                          flush,
  output logic [INSN_WIDTH-1:0]         insn_out,
  output logic                          stall,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SB_W  = $clog2(WB_LAT + 1);
  localparam logic [SB_W-1:0]  SB_LOAD = SB_W'(WB_LAT);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // FIFO storage and control
  logic [INSN_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // Output registers
  logic [INSN_WIDTH-1:0] insn_out_q, insn_out_d;
  logic                  stall_q, stall_d;

  // Head decode
  logic [INSN_WIDTH-1:0] head;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [4:0]            vd, vs1, vs2;
  logic                  head_valid, is_vec, uses_vs1;
  logic                  hazard, push, pop, issue_vec;

  // One bit per register: a write to it is still in flight
  logic [NUM_VEC-1:0]    busy;

  assign head   = mem_q[rd_ptr_q];
  assign opcode = head[6:0];
  assign vd     = head[11:7];
  assign funct3 = head[14:12];
  assign vs1    = head[19:15];
  assign vs2    = head[24:20];

  assign head_valid = (count_q != '0);
  // funct3 111 is vsetvl: no vector register operands to track
  assign is_vec     = (opcode == 7'h57) && (funct3 != 3'b111);
  // Only the VV forms (000/001/010) read vs1; the other forms carry a scalar or
  // immediate in that field, so it must not create a false dependency.
  assign uses_vs1   = (funct3 <= 3'b010);

  assign hazard = head_valid && is_vec &&
                  (busy[vs2] || busy[vd] || (uses_vs1 && busy[vs1]));

  assign insn_ready = (count_q < DEPTH_C);
  assign push       = insn_valid && insn_ready && (insn_in != '0) && !flush;
  assign pop        = head_valid && !hazard && !flush;
  assign issue_vec  = pop && is_vec;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    insn_out_d = '0;
    stall_d    = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      insn_out_d = pop ? head : '0;
      stall_d    = hazard;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      insn_out_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      insn_out_q <= insn_out_d;
      stall_q    <= stall_d;
    end
  end

  // Storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= insn_in;
  end

  // Writeback countdown scoreboard. Flush leaves it alone because writes that
  // already issued will still land. A reload on issue wins over the decrement.
  for (genvar gi = 0; gi < NUM_VEC; gi++) begin : g_sb
    logic [SB_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (issue_vec && (vd == 5'(gi))) begin
        cnt_d = SB_LOAD;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - SB_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign busy[gi] = (cnt_q != '0);
  end

  assign insn_out   = insn_out_q;
  assign stall      = stall_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_rvv_insn_issue.sv
module tb_rvv_insn_issue;
  localparam int WB_LAT = 2;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] insn_in = '0;
  logic        insn_valid = 1'b0;
  logic        flush = 1'b0;
  logic        insn_ready;
  logic [31:0] insn_out;
  logic        stall;
  logic [2:0]  fifo_count;

  rvv_insn_issue #(
    .INSN_WIDTH(32), .NUM_VEC(32), .FIFO_DEPTH(DEPTH), .WB_LAT(WB_LAT)
  ) dut (
    .clk(clk), .rst(rst), .insn_in(insn_in), .insn_valid(insn_valid),
    .insn_ready(insn_ready), .flush(flush), .insn_out(insn_out),
    .stall(stall), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int t = 0;

  // Reference model: a plain queue for the buffer and, per register, the
  // first tick at which a read of it is no longer blocked.
  logic [31:0] mq[$];
  int          free_at [32];

  logic [31:0] out_log[$];
  int          stall_seen = 0;
  bit          full_seen = 0;

  typedef struct {
    bit          v;
    logic [31:0] ins;
    logic [31:0] eo;
    bit          es;
    int          ec;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mkv(bit v, logic [31:0] ins, logic [31:0] eo, bit es, int ec);
    vec_t r;
    r.v = v; r.ins = ins; r.eo = eo; r.es = es; r.ec = ec;
    return r;
  endfunction

  function automatic logic [31:0] enc(int vd, int vs1, int vs2, int f3);
    return {6'b0, 1'b1, vs2[4:0], vs1[4:0], f3[2:0], vd[4:0], 7'h57};
  endfunction

  function automatic bit m_vec(logic [31:0] h);
    return (h[6:0] == 7'h57) && (h[14:12] != 3'b111);
  endfunction

  function automatic bit m_haz(logic [31:0] h, int tt);
    if (!m_vec(h)) return 1'b0;
    if (tt < free_at[h[11:7]]) return 1'b1;
    if (tt < free_at[h[24:20]]) return 1'b1;
    if ((h[14:12] <= 3'b010) && (tt < free_at[h[19:15]])) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    foreach (free_at[i]) free_at[i] = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s tick=%0d got=%h want=%h", nm, t, act, exp);
    end
  endtask

  // One clock edge: drive inputs, advance the model, compare after the edge.
  task automatic tick(input bit v, input logic [31:0] ins, input bit fl, output bit acc);
    logic [31:0] eo;
    logic [31:0] h;
    bit          es;
    bit          rdy;
    insn_valid = v;
    insn_in    = ins;
    flush      = fl;
    t++;
    eo  = '0;
    es  = 1'b0;
    acc = 1'b0;
    rdy = (mq.size() < DEPTH);
    if (fl) begin
      mq.delete();
    end else begin
      if (mq.size() != 0) begin
        h = mq[0];
        if (m_haz(h, t)) begin
          es = 1'b1;
        end else begin
          eo = mq.pop_front();
          if (m_vec(h)) free_at[h[11:7]] = t + WB_LAT + 1;
        end
      end
      if (v && rdy && (ins != '0)) begin
        mq.push_back(ins);
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("out", insn_out, eo);
    chk("stall", 32'(stall), 32'(es));
    chk("count", 32'(fifo_count), 32'(mq.size()));
    chk("ready", 32'(insn_ready), (mq.size() < DEPTH) ? 32'd1 : 32'd0);
    if (insn_out != '0) begin
      out_log.push_back(insn_out);
      $display("issue tick=%0d insn=%h count=%0d", t, insn_out, fifo_count);
    end
    if (stall) stall_seen++;
    if ((fifo_count == 3'd4) && !insn_ready) full_seen = 1'b1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 1'b0, a);
  endtask

  // Upstream holds an instruction until it is accepted, with a cycle budget.
  task automatic push_hold(input logic [31:0] ins);
    bit a;
    int n;
    a = 1'b0;
    n = 0;
    while (!a && (n < 20)) begin
      tick(1'b1, ins, 1'b0, a);
      n++;
    end
    if (!a) begin
      total++;
      bad++;
      $display("FAIL push_timeout insn=%h got=not_accepted want=accepted", ins);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          a;
    logic [31:0] exp_list[$];
    logic [31:0] ins;
    logic [31:0] r32;
    int          sel;

    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", insn_out, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(insn_ready), 32'h1);

    // Dependent chain, one row per clock edge
    tbl[0]  = mkv(1'b1, 32'h5c0000d7, 32'h0,        1'b0, 1);
    tbl[1]  = mkv(1'b1, 32'h5c008157, 32'h5c0000d7, 1'b0, 1);
    tbl[2]  = mkv(1'b1, 32'h5c0101d7, 32'h0,        1'b1, 2);
    tbl[3]  = mkv(1'b1, 32'h5c018057, 32'h0,        1'b1, 3);
    tbl[4]  = mkv(1'b0, 32'h0,        32'h5c008157, 1'b0, 2);
    tbl[5]  = mkv(1'b0, 32'h0,        32'h0,        1'b1, 2);
    tbl[6]  = mkv(1'b0, 32'h0,        32'h0,        1'b1, 2);
    tbl[7]  = mkv(1'b0, 32'h0,        32'h5c0101d7, 1'b0, 1);
    tbl[8]  = mkv(1'b0, 32'h0,        32'h0,        1'b1, 1);
    tbl[9]  = mkv(1'b0, 32'h0,        32'h0,        1'b1, 1);
    tbl[10] = mkv(1'b0, 32'h0,        32'h5c018057, 1'b0, 0);
    tbl[11] = mkv(1'b0, 32'h0,        32'h0,        1'b0, 0);
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].v, tbl[i].ins, 1'b0, a);
      chk("chain_out", insn_out, tbl[i].eo);
      chk("chain_stall", 32'(stall), 32'(tbl[i].es));
      chk("chain_count", 32'(fifo_count), 32'(tbl[i].ec));
    end

    // Independent stream issues back to back
    idle(4);
    stall_seen = 0;
    out_log.delete();
    exp_list = '{enc(4, 6, 5, 0), enc(7, 9, 8, 0), enc(10, 12, 11, 0)};
    foreach (exp_list[i]) tick(1'b1, exp_list[i], 1'b0, a);
    idle(4);
    chk("indep_stalls", 32'(stall_seen), 32'h0);
    chk("indep_n", 32'(out_log.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < out_log.size()) chk("indep_order", out_log[i], exp_list[i]);

    // Full FIFO behind a chain of WAW hazards on v1
    idle(4);
    out_log.delete();
    full_seen = 1'b0;
    exp_list.delete();
    for (int k = 0; k < 7; k++) exp_list.push_back(enc(1, k, 16 + k, 3));
    foreach (exp_list[k]) push_hold(exp_list[k]);
    idle(25);
    chk("full_seen", 32'(full_seen), 32'h1);
    chk("full_n", 32'(out_log.size()), 32'd7);
    for (int k = 0; k < 7; k++)
      if (k < out_log.size()) chk("full_order", out_log[k], exp_list[k]);

    // VX form: vs2 is a source, vs1 field is not
    idle(4);
    stall_seen = 0;
    tick(1'b1, enc(3, 0, 0, 0), 1'b0, a);
    tick(1'b1, enc(8, 1, 3, 4), 1'b0, a);
    idle(6);
    chk("vx_vs2_stalls", 32'(stall_seen), 32'd2);
    idle(2);
    stall_seen = 0;
    tick(1'b1, enc(3, 0, 0, 0), 1'b0, a);
    tick(1'b1, enc(10, 3, 9, 4), 1'b0, a);
    idle(6);
    chk("vx_vs1_stalls", 32'(stall_seen), 32'd0);

    // Flush with three buffered; same-cycle push is dropped
    idle(4);
    tick(1'b1, enc(6, 0, 0, 0), 1'b0, a);
    tick(1'b1, enc(6, 1, 2, 0), 1'b0, a);
    tick(1'b1, enc(11, 12, 13, 0), 1'b0, a);
    tick(1'b1, enc(14, 12, 13, 0), 1'b0, a);
    chk("pre_flush_count", 32'(fifo_count), 32'd3);
    tick(1'b1, enc(15, 12, 13, 0), 1'b1, a);
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_out", insn_out, 32'h0);
    chk("flush_stall", 32'(stall), 32'h0);
    idle(1);
    chk("flush_dropped", 32'(fifo_count), 32'd0);
    tick(1'b1, enc(16, 6, 6, 0), 1'b0, a);
    idle(4);

    // Asynchronous reset in the middle of a stall
    idle(4);
    tick(1'b1, enc(7, 0, 0, 0), 1'b0, a);
    tick(1'b1, enc(9, 7, 0, 0), 1'b0, a);
    tick(1'b0, 32'h0, 1'b0, a);
    chk("pre_rst_stall", 32'(stall), 32'h1);
    insn_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("async_rst_out", insn_out, 32'h0);
    chk("async_rst_stall", 32'(stall), 32'h0);
    chk("async_rst_count", 32'(fifo_count), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tick(1'b1, enc(9, 7, 0, 0), 1'b0, a);
    chk("post_rst_lat1", insn_out, 32'h0);
    tick(1'b0, 32'h0, 1'b0, a);
    chk("post_rst_issue", insn_out, enc(9, 7, 0, 0));
    chk("post_rst_stall", 32'(stall), 32'h0);

    // Randomised traffic against the model
    idle(4);
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: ins = 32'h0;
        1: begin
          r32 = $urandom;
          r32[6:0] = 7'h07;
          ins = r32;
        end
        2: ins = enc(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), 7);
        default: ins = enc(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                           int'($urandom_range(0, 7)), int'($urandom_range(0, 6)));
      endcase
      tick($urandom_range(0, 3) != 0, ins, $urandom_range(0, 39) == 0, a);
    end
    idle(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
